rvbridge_frame_arbiter: RTL and testbench

RVBRIDGE_FRAME_ARBITER -- requirements
Module: rvbridge_frame_arbiter

---
 rtl/rvbridge_frame_arbiter.sv | 142 ++++++++++++++
 tb/tb_rvbridge_frame_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvbridge_frame_arbiter.sv
// rvbridge_frame_arbiter: two-source Avalon-ST (VIP) frame arbiter.
// A source owns the output from an accepted startofpacket beat until the
// end of a video packet (type 0x0), or until RELEASE_TIMEOUT idle cycles
// pass inside the frame. Output is a single register stage.
// Optional feature macro: ROUND_ROBIN_EN -- on simultaneous IDLE requests
// grant the source other than grant_src (default: source 0 always wins).
module rvbridge_frame_arbiter #(
  parameter int          DATA_WIDTH      = 8,
  parameter logic [15:0] RELEASE_TIMEOUT = 16'd4096
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_valid,
  input  logic                  din0_startofpacket,
  input  logic                  din0_endofpacket,
  output logic                  din0_ready,
  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_valid,
  input  logic                  din1_startofpacket,
  input  logic                  din1_endofpacket,
  output logic                  din1_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic                  grant_src,
  output logic                  locked,
  output logic                  timeout_pulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [15:0]           idle_cnt;
  logic [3:0]            type_q;
  logic                  after_sop;

  logic                  in_idle, lock0, lock1, can_load;
  logic                  req0, req1, both_pick, idle_pick, sel;
  logic                  sel_valid, sel_sop, sel_eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  fwd, frame_end, idle_tick, tmo;
  logic [3:0]            beat_type;
  logic [15:0]           cnt_inc;

  assign in_idle  = (state_q == ST_IDLE);
  assign lock0    = (state_q == ST_LOCK0);
  assign lock1    = (state_q == ST_LOCK1);
  assign locked   = lock0 | lock1;
  assign can_load = ~dout_valid | dout_ready;

  assign req0 = din0_valid & din0_startofpacket;
  assign req1 = din1_valid & din1_startofpacket;

`ifdef ROUND_ROBIN_EN
  assign both_pick = ~grant_src;
`else
  assign both_pick = 1'b0;
`endif

  // Source chosen among IDLE requesters; in a lock it is the owner
  assign idle_pick = (req0 & req1) ? both_pick : req1;
  assign sel       = in_idle ? idle_pick : lock1;

  assign sel_valid = sel ? din1_valid         : din0_valid;
  assign sel_sop   = sel ? din1_startofpacket : din0_startofpacket;
  assign sel_eop   = sel ? din1_endofpacket   : din0_endofpacket;
  assign sel_data  = sel ? din1_data          : din0_data;

  // Beat taken into the output register this cycle
  assign fwd = can_load & (in_idle ? (req0 | req1) : (locked & sel_valid));

  // Stray mid-packet beats in IDLE are swallowed so the stream resyncs
  assign din0_ready = (in_idle & din0_valid & ~din0_startofpacket) |
                      (can_load & ~sel & (in_idle ? req0 : lock0));
  assign din1_ready = (in_idle & din1_valid & ~din1_startofpacket) |
                      (can_load &  sel & (in_idle ? req1 : lock1));

  // Type comes from the beat right after startofpacket; 1-beat packets
  // never end a frame
  assign beat_type = after_sop ? sel_data[3:0] : type_q;
  assign frame_end = fwd & locked & sel_eop & ~sel_sop & (beat_type == 4'h0);

  assign idle_tick = locked & ~sel_valid;
  assign cnt_inc   = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
  assign tmo       = idle_tick & (cnt_inc >= RELEASE_TIMEOUT);

  // Next-state: lock on an accepted request, release on frame end or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:            if (fwd) state_d = idle_pick ? ST_LOCK1 : ST_LOCK0;
      ST_LOCK0, ST_LOCK1: if (frame_end | tmo) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // FSM, grant history, idle counter, packet-type tracking
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      state_q       <= ST_IDLE;
      grant_src     <= 1'b0;
      idle_cnt      <= 16'd0;
      type_q        <= 4'hF;
      after_sop     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeout_pulse <= tmo;
      if (in_idle & fwd) grant_src <= idle_pick;
      if (in_idle | fwd | tmo) idle_cnt <= 16'd0;
      else if (idle_tick)      idle_cnt <= cnt_inc;
      if (fwd) begin
        after_sop <= sel_sop & ~sel_eop;
        if (sel_sop)        type_q <= 4'hF;
        else if (after_sop) type_q <= sel_data[3:0];
      end
    end
  end

  // Output register stage
  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      dout_valid         <= 1'b0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      dout_data          <= '0;
    end else if (can_load) begin
      dout_valid <= fwd;
      if (fwd) begin
        dout_startofpacket <= sel_sop;
        dout_endofpacket   <= sel_eop;
        dout_data          <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rvbridge_frame_arbiter.sv
// tb_rvbridge_frame_arbiter: randomized self-checking bench. Sources are
// queue-driven; expected output comes from a packet-level frame model.
module tb_rvbridge_frame_arbiter;
  localparam int          DW  = 8;
  localparam logic [15:0] TMO = 16'd16;
`ifdef ROUND_ROBIN_EN
  localparam int ARB_WIN = 1;
`else
  localparam int ARB_WIN = 0;
`endif

  typedef struct packed { logic [DW-1:0] data; logic sop; logic eop; } beat_t;

  logic          vst_clk, vst_rst_n;
  logic [DW-1:0] din0_data, din1_data, dout_data;
  logic          din0_valid, din0_startofpacket, din0_endofpacket, din0_ready;
  logic          din1_valid, din1_startofpacket, din1_endofpacket, din1_ready;
  logic          dout_valid, dout_startofpacket, dout_endofpacket, dout_ready;
  logic          grant_src, locked, timeout_pulse;

  rvbridge_frame_arbiter #(.DATA_WIDTH(DW), .RELEASE_TIMEOUT(TMO)) dut (
    .vst_clk(vst_clk), .vst_rst_n(vst_rst_n),
    .din0_data(din0_data), .din0_valid(din0_valid),
    .din0_startofpacket(din0_startofpacket), .din0_endofpacket(din0_endofpacket),
    .din0_ready(din0_ready),
    .din1_data(din1_data), .din1_valid(din1_valid),
    .din1_startofpacket(din1_startofpacket), .din1_endofpacket(din1_endofpacket),
    .din1_ready(din1_ready),
    .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .dout_ready(dout_ready), .grant_src(grant_src), .locked(locked),
    .timeout_pulse(timeout_pulse)
  );

  beat_t q0[$], q1[$], sent0[$], sent1[$], outq[$], expq[$];
  int    acc0_cyc[$], out_cyc[$];
  int    cyc = 0, n_chk = 0, n_pass = 0, rdy_mode = 0;
  logic  hs0 = 1'b0, hs1 = 1'b0;

  initial begin vst_clk = 1'b0; forever #5 vst_clk = ~vst_clk; end
  always @(posedge vst_clk) cyc <= cyc + 1;

  // Handshake / output monitor, sampled mid-cycle
  always @(negedge vst_clk) begin
    hs0 = din0_valid & din0_ready;
    hs1 = din1_valid & din1_ready;
    if (hs0) acc0_cyc.push_back(cyc);
    if (dout_valid & dout_ready) begin
      outq.push_back({dout_data, dout_startofpacket, dout_endofpacket});
      out_cyc.push_back(cyc);
    end
  end

  // Source drivers: present queue head, pop on handshake
  initial begin
    din0_valid = 0; din0_data = '0; din0_startofpacket = 0; din0_endofpacket = 0;
    forever begin
      @(posedge vst_clk);
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      #1;
      din0_valid = (q0.size() > 0);
      if (q0.size() > 0) {din0_data, din0_startofpacket, din0_endofpacket} = q0[0];
    end
  end
  initial begin
    din1_valid = 0; din1_data = '0; din1_startofpacket = 0; din1_endofpacket = 0;
    forever begin
      @(posedge vst_clk);
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      #1;
      din1_valid = (q1.size() > 0);
      if (q1.size() > 0) {din1_data, din1_startofpacket, din1_endofpacket} = q1[0];
    end
  end
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge vst_clk); #1;
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ~dout_ready;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Packet of len beats; the type nibble rides on the beat after sop
  task automatic add_pkt(input int src, input logic [3:0] ty, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = DW'($urandom);
      if (i == 1) b.data[3:0] = ty;
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      if (src == 0) begin q0.push_back(b); sent0.push_back(b); end
      else          begin q1.push_back(b); sent1.push_back(b); end
    end
  endtask

  // Random frame: 0-3 non-video packets (incl. 1-beat ones), then video
  task automatic add_frame(input int src);
    int np = $urandom_range(0, 3);
    for (int p = 0; p < np; p++)
      add_pkt(src, 4'($urandom_range(1, 15)), $urandom_range(1, 6));
    add_pkt(src, 4'h0, $urandom_range(2, 12));
  endtask

  // Frame model: outside a frame, non-sop beats vanish; a whole packet is
  // forwarded; a frame closes after a >=2-beat packet with eop and type 0
  task automatic model(input int src);
    beat_t s[$];
    bit    in_frame = 0;
    int    i = 0, j;
    if (src == 0) begin s = sent0; sent0.delete(); end
    else          begin s = sent1; sent1.delete(); end
    while (i < s.size()) begin
      if (!in_frame && !s[i].sop) i++;
      else begin
        j = i;
        while (j < s.size() - 1 && !s[j].eop) j++;
        for (int k = i; k <= j; k++) expq.push_back(s[k]);
        in_frame = !(j > i && s[j].eop && s[i+1].data[3:0] == 4'h0);
        i = j + 1;
      end
    end
  endtask

  function automatic int count_diff();
    int bad = 0;
    foreach (expq[i]) if (i >= outq.size() || outq[i] !== expq[i]) bad++;
    return bad;
  endfunction

  task automatic drain(input int lim, output bit ok);
    int n = 0;
    do begin @(negedge vst_clk); n++; end
    while ((q0.size() != 0 || q1.size() != 0 || dout_valid) && n < lim);
    ok = !(q0.size() != 0 || q1.size() != 0 || dout_valid);
  endtask

  task automatic clear_logs();
    outq.delete(); expq.delete(); acc0_cyc.delete(); out_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge vst_clk); vst_rst_n = 1'b0;
    repeat (2) @(negedge vst_clk);
    vst_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vst_rst_n = 1'b0;
    repeat (2) @(negedge vst_clk);
    n_chk++;
    if ({dout_valid, dout_startofpacket, dout_endofpacket} !== 3'b000)
      $display("FAIL reset_ctrl: got %b want 000", {dout_valid, dout_startofpacket, dout_endofpacket});
    else n_pass++;
    n_chk++;
    if (dout_data !== '0) $display("FAIL reset_data: got %h want 00", dout_data);
    else n_pass++;
    n_chk++;
    if ({grant_src, locked, timeout_pulse, din0_ready, din1_ready} !== 5'b0)
      $display("FAIL reset_status: got %b want 00000",
               {grant_src, locked, timeout_pulse, din0_ready, din1_ready});
    else n_pass++;
    vst_rst_n = 1'b1;
  endtask

  task automatic test_frame();
    bit ok; int bad;
    clear_logs(); rdy_mode = 0;
    add_pkt(0, 4'hF, 10);
    add_pkt(0, 4'h0, 16);
    model(0);
    drain(400, ok);
    n_chk++;
    if (!ok || outq.size() != 26) $display("FAIL frame_count: got %0d want 26", outq.size());
    else n_pass++;
    n_chk++;
    if (count_diff() != 0) $display("FAIL frame_data: got %0d bad beats want 0", count_diff());
    else n_pass++;
    bad = 0;
    foreach (out_cyc[i])
      if (i >= acc0_cyc.size() || out_cyc[i] - acc0_cyc[i] != 1) bad++;
    n_chk++;
    if (bad != 0 || out_cyc.size() != acc0_cyc.size())
      $display("FAIL frame_latency: got %0d late beats want 0", bad);
    else n_pass++;
    n_chk++;
    if (locked !== 1'b0) $display("FAIL frame_unlock: got %b want 0", locked);
    else n_pass++;
    // Random frames, mixed sources, one at a time
    for (int r = 0; r < 4; r++) begin
      int s = $urandom_range(0, 1);
      clear_logs();
      add_frame(s); model(s);
      drain(400, ok);
      n_chk++;
      if (!ok || count_diff() != 0 || outq.size() != expq.size())
        $display("FAIL frame_rand%0d: got %0d beats (%0d bad) want %0d", r, outq.size(), count_diff(), expq.size());
      else n_pass++;
    end
  endtask

  task automatic test_arb();
    int n = 0, viol = 0, gfirst = -1, w = ARB_WIN;
    do_reset();
    clear_logs(); rdy_mode = 0;
    add_frame(0); add_frame(1);
    model(w); model(1 - w);
    do begin
      @(negedge vst_clk); n++;
      if (locked && gfirst < 0) gfirst = grant_src;
      if (locked && grant_src == 1'(w) && (w == 1 ? din0_ready : din1_ready)) viol++;
    end while ((q0.size() != 0 || q1.size() != 0 || dout_valid) && n < 2000);
    n_chk++;
    if (gfirst != w) $display("FAIL arb_winner: got %0d want %0d", gfirst, w);
    else n_pass++;
    n_chk++;
    if (viol != 0) $display("FAIL arb_loser_stall: got %0d ready cycles want 0", viol);
    else n_pass++;
    n_chk++;
    if (n >= 2000 || count_diff() != 0 || outq.size() != expq.size())
      $display("FAIL arb_order: got %0d beats (%0d bad) want %0d", outq.size(), count_diff(), expq.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      int n = 0, viol = 0, s = (m == 1) ? 0 : 1;
      clear_logs(); rdy_mode = m;
      add_frame(s); add_frame(s); model(s);
      do begin
        @(negedge vst_clk); n++;
        if (locked && (((grant_src ? din1_ready : din0_ready) !== ~(dout_valid & ~dout_ready)) ||
                       (grant_src ? din0_ready : din1_ready) !== 1'b0)) viol++;
      end while ((q0.size() != 0 || q1.size() != 0 || dout_valid) && n < 2000);
      rdy_mode = 0;
      n_chk++;
      if (viol != 0) $display("FAIL bp_ready%0d: got %0d bad cycles want 0", m, viol);
      else n_pass++;
      n_chk++;
      if (n >= 2000 || count_diff() != 0 || outq.size() != expq.size())
        $display("FAIL bp_beats%0d: got %0d beats (%0d bad) want %0d", m, outq.size(), count_diff(), expq.size());
      else n_pass++;
    end
  endtask

  task automatic test_discard();
    int n = 0, vhi = 0;
    clear_logs(); rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b.data = DW'($urandom); b.sop = 1'b0; b.eop = 1'($urandom_range(0, 1));
      q1.push_back(b);
    end
    do begin
      @(negedge vst_clk); n++;
      if (dout_valid) vhi++;
    end while (n < 20);
    n_chk++;
    if (q1.size() != 0) $display("FAIL discard_accept: got %0d left want 0", q1.size());
    else n_pass++;
    n_chk++;
    if (vhi != 0 || outq.size() != 0 || locked)
      $display("FAIL discard_fwd: got %0d valid cycles want 0", vhi);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n = 0, pulses = 0, pcyc = -1, last;
    logic lockp = 1'b1;
    bit ok;
    do_reset();
    clear_logs(); rdy_mode = 0;
    add_pkt(0, 4'hF, 4);
    // Video packet cut short after 5 beats, no endofpacket
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b.data = DW'($urandom);
      if (i == 1) b.data[3:0] = 4'h0;
      b.sop = (i == 0); b.eop = 1'b0;
      q0.push_back(b); sent0.push_back(b);
    end
    while (q0.size() != 0 && n < 200) begin @(negedge vst_clk); n++; end
    last = acc0_cyc[acc0_cyc.size() - 1];
    add_frame(1);
    model(0); model(1);
    for (int k = 0; k < 40; k++) begin
      @(negedge vst_clk);
      if (timeout_pulse) begin
        pulses++;
        if (pcyc < 0) begin pcyc = cyc; lockp = locked; end
      end
    end
    // 16 idle cycles follow the last accepted beat; the pulse is registered
    // on the 16th idle edge, so it is seen 17 sample points later
    n_chk++;
    if (pulses != 1) $display("FAIL tmo_pulse_width: got %0d want 1", pulses);
    else n_pass++;
    n_chk++;
    if (pcyc - last != 17) $display("FAIL tmo_pulse_time: got %0d want 17", pcyc - last);
    else n_pass++;
    n_chk++;
    if (lockp !== 1'b0) $display("FAIL tmo_release: got locked=%b want 0", lockp);
    else n_pass++;
    drain(400, ok);
    n_chk++;
    if (!ok || count_diff() != 0 || outq.size() != expq.size() || grant_src !== 1'b1)
      $display("FAIL tmo_next_grant: got %0d beats (%0d bad) grant %b want %0d grant 1",
               outq.size(), count_diff(), grant_src, expq.size());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    bit ok;
    clear_logs(); rdy_mode = 0;
    add_pkt(0, 4'h0, 16);
    sent0.delete();
    while (outq.size() < 6 && n < 200) begin @(negedge vst_clk); n++; end
    @(posedge vst_clk); #3;
    vst_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({dout_valid, dout_startofpacket, dout_endofpacket, grant_src, locked, timeout_pulse} !== 6'b0 ||
        dout_data !== '0 || din1_ready !== 1'b0)
      $display("FAIL midrst_outputs: got %b/%h want 000000/00",
               {dout_valid, dout_startofpacket, dout_endofpacket, grant_src, locked, timeout_pulse}, dout_data);
    else n_pass++;
    repeat (2) @(negedge vst_clk);
    vst_rst_n = 1'b1;
    outq.delete();
    drain(200, ok);
    repeat (3) @(negedge vst_clk);
    n_chk++;
    if (!ok || outq.size() != 0 || locked !== 1'b0)
      $display("FAIL midrst_drop: got %0d beats after release want 0", outq.size());
    else n_pass++;
  endtask

  initial begin
    vst_rst_n = 1'b0;
    test_reset();
    test_frame();
    test_arb();
    test_backpressure();
    test_discard();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
